// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one byte-wide synchronous memory between instruction fetch (two-byte word)
// and a byte load/store port. Define FAIR_ARB_EN for round-robin arbitration on ties.
module mem_port_arbiter #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_req,
  input  logic [ADDR_BITS-1:0]     if_addr,
  output logic                     if_gnt,
  output logic                     if_valid,
  output logic [2*DATA_BITS-1:0]   if_instr,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDR_BITS-1:0]     d_addr,
  input  logic [DATA_BITS-1:0]     d_wdata,
  output logic                     d_gnt,
  output logic                     d_valid,
  output logic [DATA_BITS-1:0]     d_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_BITS-1:0]     mem_addr,
  output logic [DATA_BITS-1:0]     mem_wdata,
  input  logic [DATA_BITS-1:0]     mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_ACC  = 3'd1,
    D_RSP  = 3'd2,
    IF_B0  = 3'd3,
    IF_B1  = 3'd4,
    IF_RSP = 3'd5
  } state_t;

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  state_t                   state_reg;
  state_t                   state_next;
  logic [ADDR_BITS-1:0]     addr_reg;
  logic                     we_reg;
  logic [DATA_BITS-1:0]     wdata_reg;
  logic [DATA_BITS-1:0]     hi_reg;
  logic [DATA_BITS-1:0]     rdata_reg;
  logic [2*DATA_BITS-1:0]   instr_reg;
  logic                     grant_data;
  logic                     grant_fetch;
  logic                     in_idle;

  // Grants are gated by reset so every output reads 0 while reset is held.
  assign in_idle = reset && (state_reg == IDLE);

`ifdef FAIR_ARB_EN
  logic last_data_reg;

  always_comb begin
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (in_idle) begin
      if (d_req && if_req) begin
        grant_data  = !last_data_reg;
        grant_fetch = last_data_reg;
      end else begin
        grant_data  = d_req;
        grant_fetch = if_req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_data_reg <= 1'b1;
    end else if (grant_data || grant_fetch) begin
      last_data_reg <= grant_data;
    end
  end
`else
  always_comb begin
    grant_data  = in_idle && d_req;
    grant_fetch = in_idle && if_req && !d_req;
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_data) begin
          state_next = D_ACC;
        end else if (grant_fetch) begin
          state_next = IF_B0;
        end
      end
      D_ACC:   state_next = D_RSP;
      D_RSP:   state_next = IDLE;
      IF_B0:   state_next = IF_B1;
      IF_B1:   state_next = IF_RSP;
      IF_RSP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
      hi_reg    <= '0;
      rdata_reg <= '0;
      instr_reg <= '0;
    end else begin
      if (grant_data) begin
        addr_reg  <= d_addr;
        we_reg    <= d_we;
        wdata_reg <= d_wdata;
      end else if (grant_fetch) begin
        addr_reg  <= if_addr;
        we_reg    <= 1'b0;
      end
      // Read data arrives one cycle after its strobe, hence the one-state offset here.
      case (state_reg)
        IF_B1:  hi_reg    <= mem_rdata;
        IF_RSP: instr_reg <= {hi_reg, mem_rdata};
        D_RSP: begin
          if (!we_reg) begin
            rdata_reg <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_reg)
      D_ACC: begin
        mem_en    = 1'b1;
        mem_we    = we_reg;
        mem_addr  = addr_reg;
        mem_wdata = we_reg ? wdata_reg : '0;
      end
      IF_B0: begin
        mem_en   = 1'b1;
        mem_addr = addr_reg;
      end
      IF_B1: begin
        mem_en   = 1'b1;
        mem_addr = addr_reg + ADDR_ONE;
      end
      default: ;
    endcase
  end

  // Response data is forwarded from memory in the valid cycle, then held in the register.
  always_comb begin
    if_gnt   = grant_fetch;
    d_gnt    = grant_data;
    d_valid  = (state_reg == D_RSP);
    if_valid = (state_reg == IF_RSP);
    d_rdata  = (d_valid && !we_reg) ? mem_rdata : rdata_reg;
    if_instr = if_valid ? {hi_reg, mem_rdata} : instr_reg;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a byte RAM model plus a transaction-level reference
// (expected memory contents, winner choice and latencies) checks every grant and response.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [15:0] if_instr;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [7:0]  d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [7:0]  d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [7:0]  bd_data;
  logic [7:0]  ram [256];

  logic [7:0]  ref_mem [256];
  logic        model_last_data;
  logic [7:0]  model_rdata;
  logic [15:0] model_instr;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  mem_port_arbiter #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte RAM with a backdoor port used only for preload.
  always @(posedge clk) begin
    if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) chk("we_without_en", {31'b0, mem_we & ~mem_en}, 32'd0);

  // Called in an IDLE cycle with requests already driven; returns one cycle after the response.
  task automatic run_txn(input bit hold_winner, input bit inject_d);
    bit         win_d;
    bit         found;
    bit         we;
    logic [7:0] a;
    int         lat;
    int         k;
    #1;
`ifdef FAIR_ARB_EN
    win_d = d_req && (!if_req || !model_last_data);
`else
    win_d = d_req;
`endif
    chk("d_gnt", d_gnt, win_d);
    chk("if_gnt", if_gnt, !win_d);
    if (win_d) begin
      a = d_addr;
      we = d_we;
      if (we) ref_mem[a] = d_wdata;
      else model_rdata = ref_mem[a];
      lat = 2;
    end else begin
      a = if_addr;
      we = 1'b0;
      model_instr = {ref_mem[a], ref_mem[a + 8'd1]};
      lat = 3;
    end
    model_last_data = win_d;
    found = 1'b0;
    k = 0;
    while (!found && k < 8) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        if (!hold_winner) begin
          if (win_d) d_req = 1'b0;
          else if_req = 1'b0;
        end
        if (inject_d) begin
          d_req = 1'b1;
          d_we = 1'b0;
          d_addr = 8'($urandom);
        end
      end
      #1;
      chk("busy_gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
      chk("other_valid", win_d ? if_valid : d_valid, 1'b0);
      if (win_d ? d_valid : if_valid) found = 1'b1;
    end
    if (!found) chk("valid_timeout", 32'd0, 32'd1);
    else chk("latency", k, lat);
    chk("d_rdata", d_rdata, model_rdata);
    chk("if_instr", if_instr, model_instr);
    n_txn++;
    $display("txn %0d: %s addr=%02h we=%0d lat=%0d rdata=%02h instr=%04h", n_txn,
             win_d ? "DATA" : "FETCH", a, we, k, d_rdata, if_instr);
    @(negedge clk);
    #1;
    chk("hold_rdata", d_rdata, model_rdata);
    chk("hold_instr", if_instr, model_instr);
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0;
    if_addr = 8'h00;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = 8'h00;
    d_wdata = 8'h00;
    bd_we = 1'b1;
    bd_addr = 8'h00;
    bd_data = 8'h00;
    for (int i = 0; i < 256; i++) begin
      bd_addr = 8'(i);
      case (i)
        0:       bd_data = 8'h00;
        2:       bd_data = 8'h17;
        3:       bd_data = 8'hFE;
        255:     bd_data = 8'h3C;
        default: bd_data = 8'($urandom);
      endcase
      ref_mem[i] = bd_data;
      @(negedge clk);
    end
    bd_we = 1'b0;

    // Requests during reset must not produce grants.
    if_req = 1'b1;
    d_req = 1'b1;
    #1;
    chk("rst_if_gnt", if_gnt, 1'b0);
    chk("rst_d_gnt", d_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_valids", {if_valid, d_valid}, 2'b00);
    chk("rst_instr", if_instr, 16'h0);
    chk("rst_rdata", d_rdata, 8'h0);
    if_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_last_data = 1'b1;
    model_rdata = 8'h00;
    model_instr = 16'h0000;
    @(negedge clk);

    // Aligned fetch.
    if_addr = 8'h02;
    if_req = 1'b1;
    run_txn(1'b0, 1'b0);
    chk("t1_instr", if_instr, 16'h17FE);

    // Write then read back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_wdata = 8'hA5;
    run_txn(1'b0, 1'b0);
    d_req = 1'b1; d_we = 1'b0;
    run_txn(1'b0, 1'b0);
    chk("t2_rdata", d_rdata, 8'hA5);

    // Fetch across the address wrap.
    if_addr = 8'hFF;
    if_req = 1'b1;
    run_txn(1'b0, 1'b0);
    chk("t3_instr", if_instr, 16'h3C00);

    // Both requesters held high for four grants.
    if_addr = 8'h02; d_addr = 8'h40; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    repeat (4) run_txn(1'b1, 1'b0);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Reset in the second fetch byte cycle.
    if_addr = 8'h03;
    if_req = 1'b1;
    #1;
    chk("t5_gnt", if_gnt, 1'b1);
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_mem_en", mem_en, 1'b0);
    chk("t5_valid", if_valid, 1'b0);
    chk("t5_instr", if_instr, 16'h0);
    chk("t5_rdata", d_rdata, 8'h0);
    model_last_data = 1'b1;
    model_rdata = 8'h00;
    model_instr = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("t5_no_valid", if_valid, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    if_addr = 8'h02;
    if_req = 1'b1;
    run_txn(1'b0, 1'b0);

    // Data request raised while a fetch is in flight; granted right after if_valid.
    if_addr = 8'($urandom);
    if_req = 1'b1;
    run_txn(1'b0, 1'b1);
    run_txn(1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      int r;
      if ($urandom_range(0, 1) == 1) begin
        if_req = 1'b0;
        d_req = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      r = $urandom_range(1, 3);
      if_req = r[0];
      d_req = r[1];
      if_addr = 8'($urandom);
      d_we = 1'($urandom);
      d_addr = {4'h4, 4'($urandom)};
      d_wdata = 8'($urandom);
      run_txn(1'b0, 1'b0);
    end

    $display("last grant to %s", model_last_data ? "DATA" : "FETCH");
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
